// File: rtl/multi_byte_add_seq_pkg.sv
// Shared CPU package: byte width and the sequencer state encoding.
package multi_byte_add_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multi_byte_add_seq_if.sv
// CPU-side request/response bundle for the multi-byte add sequencer.
interface multi_byte_add_seq_if #(
    parameter int NUM_BYTES = 2
);
    import multi_byte_add_seq_pkg::*;

    localparam int W = BYTE_W * NUM_BYTES;

    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    // Execute stage issues requests and consumes results.
    modport master (
        output start, sub, cin, op_a, op_b,
        input  busy, done, result, carry_out, overflow, zero
    );

    // Sequencer accepts requests and produces results.
    modport slave (
        input  start, sub, cin, op_a, op_b,
        output busy, done, result, carry_out, overflow, zero
    );

endinterface

// File: rtl/multi_byte_add_seq_adder.sv
// Shared 8-bit adder that lives beside the sequencer in the parent.
module multi_byte_add_seq_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_in,
    output logic [7:0] sum,
    output logic       carry_out
);

    // Plain combinational byte add with carry in and out.
    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {8'd0, carry_in};

endmodule

// File: rtl/multi_byte_add_seq.sv
// Sequences the shared byte adder over a NUM_BYTES-wide operand, LSB first,
// chaining the carry through a register and producing result and flags.
module multi_byte_add_seq
    import multi_byte_add_seq_pkg::*;
#(
    parameter int NUM_BYTES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    multi_byte_add_seq_if.slave    bus,
    output logic [BYTE_W-1:0]      add_a,
    output logic [BYTE_W-1:0]      add_b,
    output logic                   add_cin,
    input  logic [BYTE_W-1:0]      add_sum,
    input  logic                   add_cout
);

    localparam int W     = BYTE_W * NUM_BYTES;
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     a_lat;
    logic [W-1:0]     b_lat;
    logic [W-1:0]     result_reg;
    logic [W-1:0]     result_next;
    logic             carry_reg;
    logic             carry_out_reg;
    logic             overflow_reg;
    logic             zero_reg;
    logic             last_byte;
    logic             accept;

    assign last_byte = (idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next-state logic and adder input steering; adder inputs are parked at 0 unless running.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        add_a      = '0;
        add_b      = '0;
        add_cin    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                add_a   = a_lat[BYTE_W*idx +: BYTE_W];
                add_b   = b_lat[BYTE_W*idx +: BYTE_W];
                add_cin = carry_reg;
                if (last_byte) next_state = ST_DONE;
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Result as it will look once the current byte's sum is written in.
    always_comb begin
        result_next = result_reg;
        result_next[BYTE_W*idx +: BYTE_W] = add_sum;
    end

    // Operand latching, byte accumulation and flag capture on the final byte so flags line up with done.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_lat         <= '0;
            b_lat         <= '0;
            idx           <= '0;
            carry_reg     <= 1'b0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            zero_reg      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_lat      <= bus.op_a;
                        b_lat      <= bus.op_b ^ {W{bus.sub}};
                        carry_reg  <= bus.cin ^ bus.sub;
                        idx        <= '0;
                        result_reg <= '0;
                    end
                end
                ST_RUN: begin
                    result_reg <= result_next;
                    carry_reg  <= add_cout;
                    if (!last_byte) begin
                        idx <= idx + 1'b1;
                    end else begin
                        carry_out_reg <= add_cout;
                        overflow_reg  <= (a_lat[W-1] == b_lat[W-1]) &&
                                         (result_next[W-1] != a_lat[W-1]);
                        zero_reg      <= (result_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state == ST_RUN);
    assign bus.done      = (state == ST_DONE);
    assign bus.result    = result_reg;
    assign bus.carry_out = carry_out_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.zero      = zero_reg;

endmodule

// File: tb/tb_multi_byte_add_seq.sv
// Bench for the multi-byte add sequencer wired to the shared byte adder.
module tb_multi_byte_add_seq;

    logic clk;
    logic reset;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_cin;
    logic [7:0] add_sum;
    logic       add_cout;

    int checks = 0;
    int errors = 0;

    multi_byte_add_seq_if #(.NUM_BYTES(2)) bus ();

    multi_byte_add_seq #(.NUM_BYTES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    multi_byte_add_seq_adder adder (
        .a         (add_a),
        .b         (add_b),
        .carry_in  (add_cin),
        .sum       (add_sum),
        .carry_out (add_cout)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: integer add/subtract with range checks for carry and signed overflow.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input logic s, input logic c,
                                  output logic [15:0] r, output logic co,
                                  output logic ov, output logic z);
        int ua, ub, sa, sb, ci, full, sfull;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ci = c ? 1 : 0;
        if (!s) begin
            full  = ua + ub + ci;
            sfull = sa + sb + ci;
            co    = (full > 65535);
        end else begin
            full  = ua - ub - ci;
            sfull = sa - sb - ci;
            co    = (full >= 0);
        end
        r  = full[15:0];
        ov = (sfull > 32767) || (sfull < -32768);
        z  = (r == 16'h0000);
    endfunction

    task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b,
                                  input logic s, input logic c);
        @(negedge clk);
        bus.op_a  = a;
        bus.op_b  = b;
        bus.sub   = s;
        bus.cin   = c;
        bus.start = 1'b1;
    endtask

    task automatic check_output(input string tag, input logic [15:0] er,
                                input logic eco, input logic eov, input logic ez);
        check({tag, ".done"},     32'(bus.done),      32'd1);
        check({tag, ".busy_dn"},  32'(bus.busy),      32'd0);
        check({tag, ".result"},   32'(bus.result),    32'(er));
        check({tag, ".carry"},    32'(bus.carry_out), 32'(eco));
        check({tag, ".overflow"}, 32'(bus.overflow),  32'(eov));
        check({tag, ".zero"},     32'(bus.zero),      32'(ez));
        check({tag, ".idle_a"},   32'(add_a),         32'd0);
    endtask

    // One full operation with fixed-latency checks; optionally pokes a second start mid-run.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic c, input logic poke);
        logic [15:0] er, bb;
        logic        eco, eov, ez;
        logic [8:0]  low;
        model(a, b, s, c, er, eco, eov, ez);
        bb  = s ? ~b : b;
        low = {1'b0, a[7:0]} + {1'b0, bb[7:0]} + {8'd0, c ^ s};
        apply_stimulus(a, b, s, c);
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, ".busy1"}, 32'(bus.busy), 32'd1);
        check({tag, ".done1"}, 32'(bus.done), 32'd0);
        check({tag, ".a0"},    32'(add_a),    32'(a[7:0]));
        check({tag, ".b0"},    32'(add_b),    32'(bb[7:0]));
        check({tag, ".cin0"},  32'(add_cin),  32'(c ^ s));
        if (poke) begin
            bus.start = 1'b1;
            bus.op_a  = ~a;
            bus.op_b  = a ^ b ^ 16'h5A5A;
            bus.sub   = ~s;
            bus.cin   = ~c;
        end
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, ".busy2"}, 32'(bus.busy), 32'd1);
        check({tag, ".done2"}, 32'(bus.done), 32'd0);
        check({tag, ".a1"},    32'(add_a),    32'(a[15:8]));
        check({tag, ".b1"},    32'(add_b),    32'(bb[15:8]));
        check({tag, ".cin1"},  32'(add_cin),  32'(low[8]));
        @(negedge clk);
        check_output(tag, er, eco, eov, ez);
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(bus.done),   32'd0);
        check({tag, ".idle_busy"},  32'(bus.busy),   32'd0);
        check({tag, ".held"},       32'(bus.result), 32'(er));
    endtask

    // Directed scenarios followed by random operations.
    initial begin
        logic [15:0] ra, rb;
        logic        rs, rc;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (2) @(negedge clk);
        check("rst.busy",   32'(bus.busy),      32'd0);
        check("rst.done",   32'(bus.done),      32'd0);
        check("rst.result", 32'(bus.result),    32'd0);
        check("rst.carry",  32'(bus.carry_out), 32'd0);
        check("rst.ovf",    32'(bus.overflow),  32'd0);
        check("rst.zero",   32'(bus.zero),      32'd0);
        reset = 1'b0;

        run_op("add",    16'h1234, 16'h0FCD, 1'b0, 1'b0, 1'b0);
        run_op("wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op("sovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op("sub",    16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
        run_op("subcin", 16'h0005, 16'h0005, 1'b1, 1'b1, 1'b0);
        run_op("addcin", 16'h00FF, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_op("ignore", 16'h0102, 16'h0304, 1'b0, 1'b0, 1'b1);

        // Abort during the first RUN cycle.
        apply_stimulus(16'hABCD, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check("abort.busy",   32'(bus.busy),   32'd0);
        check("abort.done",   32'(bus.done),   32'd0);
        check("abort.result", 32'(bus.result), 32'd0);
        check("abort.add_a",  32'(add_a),      32'd0);
        check("abort.carry",  32'(bus.carry_out), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort.nodone", 32'(bus.done), 32'd0);
        check("abort.nobusy", 32'(bus.busy), 32'd0);
        run_op("fresh", 16'h4321, 16'h1234, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            rc = 1'($urandom);
            run_op($sformatf("rnd%0d", i), ra, rb, rs, rc, 1'($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
